// File: rtl/sseg_capture.sv
// Recovers the four digit patterns of a multiplexed seven-segment display by
// sampling its digit enables and segment bus, with a no-activity watchdog.
module sseg_capture #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT_W  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an_in,
  input  logic [7:0] sseg_in,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [3:0] valid,
  output logic       frame_stb,
  output logic       an_err,
  output logic       timeout
);

  localparam logic [7:0]           RUN_MAX = 8'(STABLE_CNT);
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;

  logic [3:0]           an_s1, an_s2;
  logic [7:0]           ss_s1, ss_s2;
  logic [1:0]           idx, prev_idx;
  logic [7:0]           prev_ss;
  logic                 digit_ok, illegal;
  logic [7:0]           run_cnt, run_next;
  logic                 capture;
  logic [3:0]           cap_mask, seen, seen_upd;
  logic                 frame_hit;
  logic [TIMEOUT_W-1:0] wd_cnt, wd_next;
  logic                 wd_hit;
  logic [7:0]           outs [4];

  assign out0 = outs[0];
  assign out1 = outs[1];
  assign out2 = outs[2];
  assign out3 = outs[3];

  always_comb begin
    idx      = 2'd0;
    digit_ok = 1'b1;
    illegal  = 1'b0;
    case (an_s2)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      4'b1111: digit_ok = 1'b0;
      default: begin
        digit_ok = 1'b0;
        illegal  = 1'b1;
      end
    endcase
  end

  // A zero run count means "no run in progress", so a sample equal to the one
  // before an idle gap still starts a fresh run.
  always_comb begin
    run_next = 8'd0;
    if (digit_ok) begin
      if (run_cnt != 8'd0 && idx == prev_idx && ss_s2 == prev_ss)
        run_next = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + 8'd1;
      else
        run_next = 8'd1;
    end
  end

  always_comb begin
    capture   = digit_ok && (run_next == RUN_MAX) && (run_cnt != RUN_MAX);
    cap_mask  = capture ? (4'b0001 << idx) : 4'b0000;
    seen_upd  = seen | cap_mask;
    frame_hit = capture && (seen_upd == 4'hF);
    if (capture)
      wd_next = '0;
    else if (wd_cnt == WD_MAX)
      wd_next = WD_MAX;
    else
      wd_next = wd_cnt + 1'b1;
    wd_hit = (wd_next == WD_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_s1     <= 4'hF;
      an_s2     <= 4'hF;
      ss_s1     <= 8'hFF;
      ss_s2     <= 8'hFF;
      prev_idx  <= 2'd0;
      prev_ss   <= 8'hFF;
      run_cnt   <= 8'd0;
      seen      <= 4'h0;
      valid     <= 4'h0;
      wd_cnt    <= '0;
      frame_stb <= 1'b0;
      an_err    <= 1'b0;
      timeout   <= 1'b0;
      for (int i = 0; i < 4; i++) outs[i] <= 8'hFF;
    end else begin
      an_s1     <= an_in;
      an_s2     <= an_s1;
      ss_s1     <= sseg_in;
      ss_s2     <= ss_s1;
      prev_idx  <= idx;
      prev_ss   <= ss_s2;
      run_cnt   <= run_next;
      wd_cnt    <= wd_next;
      timeout   <= wd_hit;
      frame_stb <= frame_hit;
      an_err    <= illegal;
      if (capture) outs[idx] <= ss_s2;
      // wd_hit can only be true on a cycle without a capture
      if (wd_hit) begin
        valid <= 4'h0;
        seen  <= 4'h0;
      end else begin
        valid <= valid | cap_mask;
        seen  <= frame_hit ? 4'h0 : seen_upd;
      end
    end
  end

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: directed scenarios plus random display traffic,
// all checked against a sample-history reference model.
module tb_sseg_capture;

  localparam int S   = 4;
  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  localparam logic [3:0] D0 = 4'b1110;
  localparam logic [3:0] D1 = 4'b1101;
  localparam logic [3:0] D2 = 4'b1011;
  localparam logic [3:0] D3 = 4'b0111;
  localparam logic [3:0] IDLE = 4'b1111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] an_in = 4'hF;
  logic [7:0] sseg_in = 8'hFF;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] valid;
  logic       frame_stb, an_err, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  sseg_capture #(.STABLE_CNT(S), .TIMEOUT_W(W)) dut (
    .clk(clk), .reset(reset), .an_in(an_in), .sseg_in(sseg_in),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid(valid), .frame_stb(frame_stb), .an_err(an_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [3:0] m_an1, m_an2;
  logic [7:0] m_ss1, m_ss2;
  logic [7:0] e_out [4];
  logic [3:0] e_valid, m_seen;
  logic       e_frame, e_err, e_to;
  int         m_idle;
  int         h_d [$];
  logic [7:0] h_s [$];

  function automatic int decode(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      4'b1111: return -1;
      default: return -2;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model at the rising edge, and
  // return at the following falling edge where outputs are sampled.
  task automatic cycle(input logic r, input logic [3:0] a, input logic [7:0] s);
    int d, k;
    logic cap;
    reset = r; an_in = a; sseg_in = s;
    @(posedge clk);
    if (r) begin
      m_an1 = 4'hF; m_an2 = 4'hF; m_ss1 = 8'hFF; m_ss2 = 8'hFF;
      for (int i = 0; i < 4; i++) e_out[i] = 8'hFF;
      e_valid = 4'h0; m_seen = 4'h0; e_frame = 1'b0; e_err = 1'b0; e_to = 1'b0;
      m_idle = 0;
      h_d.delete(); h_s.delete();
    end else begin
      d = decode(m_an2);
      e_err = (d == -2);
      e_frame = 1'b0;
      cap = 1'b0;
      h_d.push_back(d); h_s.push_back(m_ss2);
      if (h_d.size() > S + 1) begin
        void'(h_d.pop_front()); void'(h_s.pop_front());
      end
      if (d >= 0) begin
        k = 0;
        for (int i = h_d.size() - 1; i >= 0; i--) begin
          if (h_d[i] == d && h_s[i] == m_ss2) k++;
          else break;
        end
        cap = (k == S);
      end
      if (cap) begin
        e_out[d] = m_ss2;
        e_valid[d] = 1'b1;
        m_seen[d] = 1'b1;
        if (m_seen == 4'hF) begin
          e_frame = 1'b1;
          m_seen = 4'h0;
        end
        m_idle = 0;
        e_to = 1'b0;
      end else begin
        if (m_idle < MAX) m_idle++;
        if (m_idle == MAX) begin
          e_to = 1'b1; e_valid = 4'h0; m_seen = 4'h0;
        end
      end
      m_an2 = m_an1; m_an1 = a; m_ss2 = m_ss1; m_ss1 = s;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    cycle(1'b1, D1, 8'h00);
    cycle(1'b1, D1, 8'h00);
    n_cmp++;
    if ({out0, out1, out2, out3} !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL reset_outs got %h exp ffffffff", {out0, out1, out2, out3});
    end
    n_cmp++;
    if ({valid, frame_stb, an_err, timeout} !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags got %b exp 0000000", {valid, frame_stb, an_err, timeout});
    end
  endtask

  task automatic test_single;
    cycle(1'b0, IDLE, 8'hFF);
    cycle(1'b0, IDLE, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, D1, 8'hC0);
      n_cmp++;
      if (out1 !== ((i >= 5) ? 8'hC0 : 8'hFF) || valid !== ((i >= 5) ? 4'b0010 : 4'b0000)) begin
        n_bad++; $display("FAIL single_latency i=%0d got out1=%h valid=%b", i, out1, valid);
      end
      n_cmp++;
      if ({out0, out2, out3} !== 24'hFFFFFF) begin
        n_bad++; $display("FAIL single_others i=%0d got %h exp ffffff", i, {out0, out2, out3});
      end
    end
  endtask

  task automatic test_frame;
    logic [7:0] pat [4];
    logic [3:0] ens [4];
    int n_pulse, i;
    pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
    ens[0] = D0; ens[1] = D1; ens[2] = D2; ens[3] = D3;
    n_pulse = 0;
    for (int f = 0; f < 2; f++)
      for (int dg = 0; dg < 4; dg++)
        for (int c = 0; c < 8; c++) begin
          i = f * 32 + dg * 8 + c;
          cycle(1'b0, ens[dg], pat[dg]);
          if (frame_stb === 1'b1) n_pulse++;
          n_cmp++;
          if (frame_stb !== (i == 29 || i == 61)) begin
            n_bad++; $display("FAIL frame_pulse i=%0d got %b", i, frame_stb);
          end
          n_cmp++;
          if ({out0, out1, out2, out3, valid, frame_stb, an_err, timeout} !==
              {e_out[0], e_out[1], e_out[2], e_out[3], e_valid, e_frame, e_err, e_to}) begin
            n_bad++;
            $display("FAIL frame_model i=%0d got %h exp %h", i,
                     {out0, out1, out2, out3, valid, frame_stb, an_err, timeout},
                     {e_out[0], e_out[1], e_out[2], e_out[3], e_valid, e_frame, e_err, e_to});
          end
        end
    n_cmp++;
    if (n_pulse != 2) begin
      n_bad++; $display("FAIL frame_count got %0d exp 2", n_pulse);
    end
    n_cmp++;
    if ({out0, out1, out2, out3} !== 32'hA1B2C3D4) begin
      n_bad++; $display("FAIL frame_outs got %h exp a1b2c3d4", {out0, out1, out2, out3});
    end
  endtask

  task automatic test_short_run;
    cycle(1'b1, IDLE, 8'hFF);
    for (int i = 0; i < 11; i++) begin
      if (i < 3) cycle(1'b0, D2, 8'h99);
      else       cycle(1'b0, D0, 8'h66);
      n_cmp++;
      if (valid[2] !== 1'b0 || out2 !== 8'hFF) begin
        n_bad++; $display("FAIL short_run i=%0d got valid2=%b out2=%h", i, valid[2], out2);
      end
    end
    n_cmp++;
    if (valid !== 4'b0001 || out0 !== 8'h66) begin
      n_bad++; $display("FAIL short_run_next got valid=%b out0=%h exp 0001 66", valid, out0);
    end
  endtask

  task automatic test_illegal;
    cycle(1'b1, IDLE, 8'hFF);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, (i == 2 || i == 3) ? 4'b1100 : D1, 8'h5A);
      n_cmp++;
      if (an_err !== (i == 4 || i == 5)) begin
        n_bad++; $display("FAIL an_err i=%0d got %b", i, an_err);
      end
      n_cmp++;
      if (valid[1] !== (i >= 9)) begin
        n_bad++; $display("FAIL illegal_restart i=%0d got valid1=%b", i, valid[1]);
      end
    end
  endtask

  task automatic test_timeout;
    logic [7:0] pat [4];
    logic [3:0] ens [4];
    pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
    ens[0] = D0; ens[1] = D1; ens[2] = D2; ens[3] = D3;
    cycle(1'b1, IDLE, 8'hFF);
    for (int i = 0; i < 32; i++) cycle(1'b0, ens[i / 8], pat[i / 8]);
    for (int i = 32; i < 56; i++) begin
      cycle(1'b0, IDLE, 8'hFF);
      n_cmp++;
      if (timeout !== (i >= 44) || valid !== ((i >= 44) ? 4'h0 : 4'hF)) begin
        n_bad++; $display("FAIL timeout_assert i=%0d got to=%b valid=%b", i, timeout, valid);
      end
      n_cmp++;
      if ({out0, out1, out2, out3} !== 32'hA1B2C3D4) begin
        n_bad++; $display("FAIL timeout_retain i=%0d got %h", i, {out0, out1, out2, out3});
      end
    end
    for (int j = 0; j < 8; j++) begin
      cycle(1'b0, D2, 8'h77);
      n_cmp++;
      if (timeout !== (j < 5) || valid !== ((j >= 5) ? 4'b0100 : 4'b0000) ||
          out2 !== ((j >= 5) ? 8'h77 : 8'hC3)) begin
        n_bad++; $display("FAIL timeout_release j=%0d got to=%b valid=%b out2=%h", j, timeout, valid, out2);
      end
    end
  endtask

  task automatic test_reset_midrun;
    cycle(1'b1, IDLE, 8'hFF);
    for (int i = 0; i < 7; i++) cycle(1'b0, D0, 8'h11);
    for (int i = 0; i < 13; i++) begin
      cycle(i == 5, D1, 8'h3C);
      n_cmp++;
      if (i == 4 && (valid !== 4'b0001 || out0 !== 8'h11)) begin
        n_bad++; $display("FAIL midrun_pre got valid=%b out0=%h", valid, out0);
      end else if (i >= 5 && i <= 10 &&
                   ({out0, out1, out2, out3} !== 32'hFFFF_FFFF || valid !== 4'h0 || timeout !== 1'b0)) begin
        n_bad++; $display("FAIL midrun_reset i=%0d got %h valid=%b", i, {out0, out1, out2, out3}, valid);
      end else if (i >= 11 && (out1 !== 8'h3C || valid !== 4'b0010)) begin
        n_bad++; $display("FAIL midrun_recapture i=%0d got out1=%h valid=%b", i, out1, valid);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] bad_en [4];
    logic [7:0] segs [4];
    logic [3:0] a;
    logic [7:0] s;
    int r, hold;
    bad_en[0] = 4'b0000; bad_en[1] = 4'b1100; bad_en[2] = 4'b0101; bad_en[3] = 4'b0011;
    segs[0] = 8'h3F; segs[1] = 8'h06; segs[2] = 8'h5B; segs[3] = 8'h4F;
    cycle(1'b1, IDLE, 8'hFF);
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = ~(4'b0001 << (r % 4));
      else if (r < 8) a = IDLE;
      else            a = bad_en[$urandom_range(0, 3)];
      s = segs[$urandom_range(0, 3)];
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        cycle(1'b0, a, s);
        n_cmp++;
        if ({out0, out1, out2, out3, valid, frame_stb, an_err, timeout} !==
            {e_out[0], e_out[1], e_out[2], e_out[3], e_valid, e_frame, e_err, e_to}) begin
          n_bad++;
          $display("FAIL random_model n=%0d got %h exp %h", n,
                   {out0, out1, out2, out3, valid, frame_stb, an_err, timeout},
                   {e_out[0], e_out[1], e_out[2], e_out[3], e_valid, e_frame, e_err, e_to});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_short_run();
    test_illegal();
    test_timeout();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
